// File: rtl/iq_push_ctrl_pkg.sv
// ============================================================================
// Module      : iq_push_ctrl_pkg
// Description : Shared instruction-type constants, superscalar sizing and the
//               push-bundle struct for the instruction-queue push path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_push_ctrl_pkg;

  localparam int LOG_SUPERSCALAR_WIDTH = 4;
  localparam int SUPERSCALAR_WIDTH     = 1 << LOG_SUPERSCALAR_WIDTH;

  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;

  typedef struct packed {
    logic [1:0]                       instr_type;
    logic [LOG_SUPERSCALAR_WIDTH:0]   copy_count;
    logic [10:0]                      cache_addr;
    logic [10:0]                      d_cache_addr;
    logic [6:0]                       mm_addr;
    logic [6:0]                       d_mm_addr;
    logic [8:0]                       arith;
    logic [2:0]                       ram;
    logic [6:0]                       ldst;
  } iq_push_t;

  // The fourth encoding of the 2-bit type field has no meaning.
  function automatic logic type_is_legal(input logic [1:0] t);
    return (t == INSTR_TYPE_RAM) || (t == INSTR_TYPE_LOAD_STORE) ||
           (t == INSTR_TYPE_ARITHMETIC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_push_ctrl.sv
// ============================================================================
// Module      : iq_push_ctrl
// Description : Registers decoded instructions onto the instruction-queue push
//               port and sequences the queue's drain/refresh cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_push_ctrl
  import iq_push_ctrl_pkg::*;
#(
  parameter int LOG_SS_WIDTH   = LOG_SUPERSCALAR_WIDTH,
  parameter int DRAIN_CYCLES   = 2,
  parameter int REFRESH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [1:0]            dec_type,
  input  logic [LOG_SS_WIDTH:0] dec_copy_count,
  input  logic [10:0]           dec_cache_addr,
  input  logic [10:0]           dec_d_cache_addr,
  input  logic [6:0]            dec_mm_addr,
  input  logic [6:0]            dec_d_mm_addr,
  input  logic [8:0]            dec_arith,
  input  logic [2:0]            dec_ram,
  input  logic [6:0]            dec_ldst,
  output logic                  iq_we,
  output logic [1:0]            iq_type,
  output logic [LOG_SS_WIDTH:0] iq_copy_count,
  output logic [10:0]           iq_cache_addr,
  output logic [10:0]           iq_d_cache_addr,
  output logic [6:0]            iq_mm_addr,
  output logic [6:0]            iq_d_mm_addr,
  output logic [8:0]            iq_arith,
  output logic [2:0]            iq_ram,
  output logic [6:0]            iq_ldst,
  input  logic                  iq_needs_reset,
  input  logic                  iq_empty,
  output logic                  iq_reset,
  output logic                  err_illegal,
  output logic [31:0]           group_count,
  output logic [15:0]           refresh_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    REFRESH = 2'd2,
    SETTLE  = 2'd3
  } state_e;

  localparam int CNT_MAX = (DRAIN_CYCLES > REFRESH_CYCLES) ? DRAIN_CYCLES : REFRESH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [LOG_SS_WIDTH:0] CC_MAX = {1'b1, {LOG_SS_WIDTH{1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  iq_push_t           push_q, push_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [31:0]        group_q, group_d;
  logic [15:0]        refresh_q, refresh_d;
  logic               accept;
  logic [LOG_SS_WIDTH:0] cc_sat;

  // Reset gating keeps the decoder from seeing ready while the block is held.
  assign dec_ready = reset && (state_q == RUN) && !iq_needs_reset;
  assign accept    = dec_valid && dec_ready;
  assign cc_sat    = (dec_copy_count > CC_MAX) ? CC_MAX : dec_copy_count;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push_d    = push_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    group_d   = group_q;
    refresh_d = refresh_q;

    if (accept) begin
      if (!type_is_legal(dec_type)) begin
        err_d = 1'b1;
      end else if (dec_copy_count != '0) begin
        we_d                = 1'b1;
        group_d             = group_q + 32'd1;
        push_d.instr_type   = dec_type;
        push_d.copy_count   = cc_sat;
        push_d.cache_addr   = dec_cache_addr;
        push_d.d_cache_addr = dec_d_cache_addr;
        push_d.mm_addr      = dec_mm_addr;
        push_d.d_mm_addr    = dec_d_mm_addr;
        push_d.arith        = dec_arith;
        push_d.ram          = dec_ram;
        push_d.ldst         = dec_ldst;
      end
    end

    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (iq_needs_reset) state_d = DRAIN;
      end
      DRAIN: begin
        // A push still leaving the register stage makes the empty flag stale.
        if (iq_empty && !we_q) begin
          if (cnt_inc == CNT_W'(DRAIN_CYCLES)) begin
            state_d = REFRESH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      REFRESH: begin
        if (cnt_inc == CNT_W'(REFRESH_CYCLES)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SETTLE: begin
        cnt_d     = '0;
        refresh_d = (refresh_q == 16'hFFFF) ? refresh_q : refresh_q + 16'd1;
        state_d   = iq_needs_reset ? DRAIN : RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      push_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      group_q   <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      push_q    <= push_d;
      we_q      <= we_d;
      err_q     <= err_d;
      group_q   <= group_d;
      refresh_q <= refresh_d;
    end
  end

  assign iq_we           = we_q;
  assign iq_reset        = (state_q == REFRESH);
  assign err_illegal     = err_q;
  assign group_count     = group_q;
  assign refresh_count   = refresh_q;
  assign iq_type         = push_q.instr_type;
  assign iq_copy_count   = push_q.copy_count;
  assign iq_cache_addr   = push_q.cache_addr;
  assign iq_d_cache_addr = push_q.d_cache_addr;
  assign iq_mm_addr      = push_q.mm_addr;
  assign iq_d_mm_addr    = push_q.d_mm_addr;
  assign iq_arith        = push_q.arith;
  assign iq_ram          = push_q.ram;
  assign iq_ldst         = push_q.ldst;

endmodule

`default_nettype wire
